// File: rtl/pri_frame_monitor.sv
// pri_frame_monitor
//   Receive-side checker for a framed PRI pulse train (SOF strobe, burst of
//   PRI pulses, EOF strobe). It measures each pulse's high width and its
//   rising-edge-to-rising-edge period, and counts the pulses in each frame.
//   Measurements are checked against expected values within +/-TOL, and a
//   per-frame verdict is reported along with sticky error flags.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   sof          start-of-frame level
//   pri          PRI pulse train
//   eof          end-of-frame level
//   busy         high while a frame is being monitored (state != IDLE)
//   pulse_count  pulses in the current/last frame (saturates at 255)
//   last_width   width of the most recent completed pulse (saturates)
//   last_period  period of the most recent measured pulse pair (saturates)
//   width_err    sticky: a pulse width was out of tolerance or truncated
//   period_err   sticky: a period was out of tolerance
//   count_err    sticky: pulse count != N_PULSES at eof
//   timeout_err  sticky: the frame was aborted by timeout
//   frame_done   one-cycle strobe at frame end (eof or timeout)
//   frame_ok     frame verdict, valid from the frame_done cycle until next sof
module pri_frame_monitor #(
  parameter int ON_CYCLES     = 2048,
  parameter int PERIOD_CYCLES = 6145,
  parameter int TOL           = 2,
  parameter int N_PULSES      = 50,
  parameter int TIMEOUT       = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sof,
  input  logic        pri,
  input  logic        eof,
  output logic        busy,
  output logic [7:0]  pulse_count,
  output logic [15:0] last_width,
  output logic [15:0] last_period,
  output logic        width_err,
  output logic        period_err,
  output logic        count_err,
  output logic        timeout_err,
  output logic        frame_done,
  output logic        frame_ok
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0]        ON_EXP  = 16'(ON_CYCLES);
  localparam logic [15:0]        PER_EXP = 16'(PERIOD_CYCLES);
  localparam logic signed [16:0] TOL_S   = 17'(TOL);
  localparam logic [7:0]         N_EXP   = 8'(N_PULSES);
  localparam logic [TW-1:0]      TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SOF, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic          sof_d_reg, pri_d_reg, eof_d_reg;
  logic [15:0]   width_cnt_reg, width_cnt_next;
  logic [15:0]   period_cnt_reg, period_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [7:0]    pulse_count_reg, pulse_count_next;
  logic [15:0]   last_width_reg, last_width_next;
  logic [15:0]   last_period_reg, last_period_next;
  logic          width_err_reg, width_err_next;
  logic          period_err_reg, period_err_next;
  logic          count_err_reg, count_err_next;
  logic          timeout_err_reg, timeout_err_next;
  logic          frame_done_reg, frame_done_next;
  logic          frame_ok_reg, frame_ok_next;
  logic          busy_reg;
  logic          do_clear, do_finish;

  wire sof_rise = sof & ~sof_d_reg;
  wire sof_fall = ~sof & sof_d_reg;
  wire pri_rise = pri & ~pri_d_reg;
  wire pri_fall = ~pri & pri_d_reg;
  wire eof_rise = eof & ~eof_d_reg;

  // |meas - expv| <= TOL in 17-bit signed arithmetic; a saturated count
  // never passes, since the true value is unknown.
  function automatic logic in_tol(input logic [15:0] meas, input logic [15:0] expv);
    logic signed [16:0] diff;
    diff   = $signed({1'b0, meas}) - $signed({1'b0, expv});
    in_tol = (meas != 16'hFFFF) && (diff <= TOL_S) && (diff >= -TOL_S);
  endfunction

  always_comb begin
    state_next       = state_reg;
    width_cnt_next   = width_cnt_reg;
    period_cnt_next  = period_cnt_reg;
    to_cnt_next      = to_cnt_reg;
    pulse_count_next = pulse_count_reg;
    last_width_next  = last_width_reg;
    last_period_next = last_period_reg;
    width_err_next   = width_err_reg;
    period_err_next  = period_err_reg;
    count_err_next   = count_err_reg;
    timeout_err_next = timeout_err_reg;
    frame_done_next  = 1'b0;
    frame_ok_next    = frame_ok_reg;
    do_clear         = 1'b0;
    do_finish        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sof_rise) begin
          do_clear   = 1'b1;
          state_next = SOF;
        end
      end
      SOF: begin
        if (sof_fall) begin
          state_next  = RUN;
          to_cnt_next = '0;
        end
      end
      RUN: begin
        if (sof_rise) begin
          // Restart on a new sof: no verdict for the abandoned frame.
          do_clear   = 1'b1;
          state_next = SOF;
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
          if (width_cnt_reg != 16'hFFFF)
            width_cnt_next = width_cnt_reg + 16'd1;
          if (period_cnt_reg != 16'hFFFF)
            period_cnt_next = period_cnt_reg + 16'd1;

          if (pri_rise) begin
            width_cnt_next = 16'd1;
            if (pulse_count_reg != 8'hFF)
              pulse_count_next = pulse_count_reg + 8'd1;
            // A period exists only once a previous rising edge was seen.
            if (pulse_count_reg != 8'd0) begin
              if (!in_tol(period_cnt_reg, PER_EXP))
                period_err_next = 1'b1;
              last_period_next = period_cnt_reg;
            end
            period_cnt_next = 16'd1;
          end

          if (pri_fall) begin
            if (!in_tol(width_cnt_reg, ON_EXP))
              width_err_next = 1'b1;
            last_width_next = width_cnt_reg;
          end

          if (pri_rise || pri_fall)
            to_cnt_next = '0;

          // eof is evaluated after the pulse bookkeeping above so that a
          // coincident pri rise is already counted.
          if (eof_rise) begin
            if (pri)
              width_err_next = 1'b1;
            if (pulse_count_next != N_EXP)
              count_err_next = 1'b1;
            do_finish = 1'b1;
          end else if (!(pri_rise || pri_fall) && to_cnt_reg == TO_LAST) begin
            // Fires on the cycle the counter would reach TIMEOUT.
            timeout_err_next = 1'b1;
            do_finish        = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (do_finish) begin
      state_next      = DONE;
      frame_done_next = 1'b1;
      frame_ok_next   = ~(width_err_next | period_err_next | count_err_next | timeout_err_next);
    end

    if (do_clear) begin
      width_cnt_next   = '0;
      period_cnt_next  = '0;
      to_cnt_next      = '0;
      pulse_count_next = '0;
      last_width_next  = '0;
      last_period_next = '0;
      width_err_next   = 1'b0;
      period_err_next  = 1'b0;
      count_err_next   = 1'b0;
      timeout_err_next = 1'b0;
      frame_ok_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      sof_d_reg       <= 1'b0;
      pri_d_reg       <= 1'b0;
      eof_d_reg       <= 1'b0;
      width_cnt_reg   <= '0;
      period_cnt_reg  <= '0;
      to_cnt_reg      <= '0;
      pulse_count_reg <= '0;
      last_width_reg  <= '0;
      last_period_reg <= '0;
      width_err_reg   <= 1'b0;
      period_err_reg  <= 1'b0;
      count_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_ok_reg    <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sof_d_reg       <= sof;
      pri_d_reg       <= pri;
      eof_d_reg       <= eof;
      width_cnt_reg   <= width_cnt_next;
      period_cnt_reg  <= period_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      pulse_count_reg <= pulse_count_next;
      last_width_reg  <= last_width_next;
      last_period_reg <= last_period_next;
      width_err_reg   <= width_err_next;
      period_err_reg  <= period_err_next;
      count_err_reg   <= count_err_next;
      timeout_err_reg <= timeout_err_next;
      frame_done_reg  <= frame_done_next;
      frame_ok_reg    <= frame_ok_next;
      busy_reg        <= (state_next != IDLE);
    end
  end

  assign busy        = busy_reg;
  assign pulse_count = pulse_count_reg;
  assign last_width  = last_width_reg;
  assign last_period = last_period_reg;
  assign width_err   = width_err_reg;
  assign period_err  = period_err_reg;
  assign count_err   = count_err_reg;
  assign timeout_err = timeout_err_reg;
  assign frame_done  = frame_done_reg;
  assign frame_ok    = frame_ok_reg;

endmodule

// File: tb/tb_pri_frame_monitor.sv
// Scoreboarded bench for pri_frame_monitor with shortened timing parameters.
// Stimulus pushes the expected frame verdict into a queue; a monitor pops
// and compares whenever frame_done is seen.
module tb_pri_frame_monitor;
  localparam int ON  = 20;
  localparam int PER = 50;
  localparam int TOL = 2;
  localparam int NP  = 8;
  localparam int TO  = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sof = 1'b0, pri = 1'b0, eof = 1'b0;
  logic        busy, width_err, period_err, count_err, timeout_err, frame_done, frame_ok;
  logic [7:0]  pulse_count;
  logic [15:0] last_width, last_period;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int pc; int lw; int lp;
    int we; int pe; int ce; int te; int ok;
    int done_cyc;
  } exp_t;

  typedef struct {
    string name;
    int n; int bidx; int bw; int bp;
    int pc; int we; int pe; int ce; int ok;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  pri_frame_monitor #(
    .ON_CYCLES(ON), .PERIOD_CYCLES(PER), .TOL(TOL), .N_PULSES(NP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .sof(sof), .pri(pri), .eof(eof),
    .busy(busy), .pulse_count(pulse_count), .last_width(last_width),
    .last_period(last_period), .width_err(width_err), .period_err(period_err),
    .count_err(count_err), .timeout_err(timeout_err), .frame_done(frame_done),
    .frame_ok(frame_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare each frame_done against the oldest expectation.
  always @(negedge clk) begin
    if (frame_done) begin
      $display("frame_done @%0d: count=%0d width=%0d period=%0d errs(w,p,c,t)=%0d%0d%0d%0d ok=%0d",
               cyc, pulse_count, last_width, last_period,
               width_err, period_err, count_err, timeout_err, frame_ok);
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_count", 64'(pulse_count), 64'(e.pc));
        chk("last_width", 64'(last_width), 64'(e.lw));
        chk("last_period", 64'(last_period), 64'(e.lp));
        chk("width_err", 64'(width_err), 64'(e.we));
        chk("period_err", 64'(period_err), 64'(e.pe));
        chk("count_err", 64'(count_err), 64'(e.ce));
        chk("timeout_err", 64'(timeout_err), 64'(e.te));
        chk("frame_ok", 64'(frame_ok), 64'(e.ok));
        if (e.done_cyc >= 0)
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
      end
    end
  end

  task automatic send_sof();
    sof = 1'b1; step(4);
    sof = 1'b0; step(10);
  endtask

  // n pulses; pulse bidx uses width bw / period bp. Returns the cycle count
  // at the negedge where the last pulse was driven low.
  task automatic send_pulses(input int n, input int bidx, input int bw, input int bp,
                             output int fall_cyc);
    int w, p;
    fall_cyc = 0;
    for (int i = 0; i < n; i++) begin
      w = ON; p = PER;
      if (i == bidx) begin w = bw; p = bp; end
      pri = 1'b1; step(w);
      pri = 1'b0;
      fall_cyc = cyc;
      step(p - w);
    end
  endtask

  task automatic send_eof();
    step(20);
    eof = 1'b1; step(5);
    eof = 1'b0; step(5);
  endtask

  task automatic drain(input string name, input int limit);
    for (int k = 0; k < limit && exp_q.size() != 0; k++) step(1);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    int fc;

    vecs[0] = '{"nominal",      NP,     -1, ON,     PER,     NP,     0, 0, 0, 1};
    vecs[1] = '{"width_hi_err", NP,      3, ON + 3, PER,     NP,     1, 0, 0, 0};
    vecs[2] = '{"width_hi_ok",  NP,      3, ON + 2, PER,     NP,     0, 0, 0, 1};
    vecs[3] = '{"width_lo_ok",  NP,      3, ON - 2, PER,     NP,     0, 0, 0, 1};
    vecs[4] = '{"width_lo_err", NP,      3, ON - 3, PER,     NP,     1, 0, 0, 0};
    vecs[5] = '{"period_err",   NP,      3, ON,     PER + 3, NP,     0, 1, 0, 0};
    vecs[6] = '{"period_ok",    NP,      3, ON,     PER + 2, NP,     0, 0, 0, 1};
    vecs[7] = '{"short_frame",  NP - 1, -1, ON,     PER,     NP - 1, 0, 0, 1, 0};

    step(3);
    chk("reset_outputs",
        {17'd0, busy, pulse_count, last_width, last_period, width_err, period_err,
         count_err, timeout_err, frame_done, frame_ok}, 64'd0);
    reset = 1'b0;
    step(5);
    chk("idle_busy", 64'(busy), 64'd0);

    // Directed frames from the table.
    for (int v = 0; v < 8; v++) begin
      $display("vector %s: pulses=%0d idx=%0d w=%0d p=%0d", vecs[v].name, vecs[v].n,
               vecs[v].bidx, vecs[v].bw, vecs[v].bp);
      send_sof();
      chk("busy_in_frame", 64'(busy), 64'd1);
      send_pulses(vecs[v].n, vecs[v].bidx, vecs[v].bw, vecs[v].bp, fc);
      e = '{vecs[v].pc, ON, PER, vecs[v].we, vecs[v].pe, vecs[v].ce, 0, vecs[v].ok, -1};
      exp_q.push_back(e);
      send_eof();
      drain("pending_frame", 50);
      step(10);
    end

    // Timeout: eof withheld; frame_done TO cycles after the fall is clocked in.
    $display("vector timeout");
    send_sof();
    send_pulses(NP, -1, ON, PER, fc);
    e = '{NP, ON, PER, 0, 0, 0, 1, 0, fc + 1 + TO};
    exp_q.push_back(e);
    drain("timeout_frame", TO + 100);
    step(2);
    chk("busy_after_timeout", 64'(busy), 64'd0);
    step(10);

    // Mid-frame sof restart: no verdict for the aborted part.
    $display("vector sof_restart");
    send_sof();
    send_pulses(4, -1, ON, PER, fc);
    send_sof();
    chk("restart_count", 64'(pulse_count), 64'd0);
    send_pulses(NP, -1, ON, PER, fc);
    e = '{NP, ON, PER, 0, 0, 0, 0, 1, -1};
    exp_q.push_back(e);
    send_eof();
    drain("restart_frame", 50);
    step(10);

    // Reset pulse mid-frame, then pri activity without sof is ignored.
    $display("vector mid_reset");
    send_sof();
    send_pulses(5, -1, ON, PER, fc);
    reset = 1'b1; step(1);
    reset = 1'b0;
    chk("mid_reset_outputs",
        {17'd0, busy, pulse_count, last_width, last_period, width_err, period_err,
         count_err, timeout_err, frame_done, frame_ok}, 64'd0);
    send_pulses(3, -1, ON, PER, fc);
    chk("post_reset_count", 64'(pulse_count), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    step(20);
    chk("leftover_expectations", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pri_frame_monitor.md
Name: pri_frame_monitor

Overview:
- Receive-side checker for the framed PRI pulse train produced by the PWM/PRI generator: SOF strobe, a burst of PRI pulses, then an EOF strobe.
- Measures every pulse's high width and rising-edge-to-rising-edge period, and counts pulses per frame.
- Compares the measurements against expected values within a tolerance and reports a per-frame pass/fail with sticky error flags.
- Sits in the radar timing test path (loopback or on-board self-test), clocked at 100 MHz alongside the generator.

Parameters:
- ON_CYCLES, 2048, expected PRI high width in clk cycles.
- PERIOD_CYCLES, 6145, expected rising-edge-to-rising-edge spacing in cycles.
- TOL, 2, allowed absolute deviation in cycles for both width and period checks.
- N_PULSES, 50, expected pulses per frame.
- TIMEOUT, 20000, maximum cycles without a pri edge or eof while a frame is active.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- sof  in  1  start-of-frame level from the generator.
- pri  in  1  PRI pulse train.
- eof  in  1  end-of-frame level.
- busy  out  1  high while a frame is being monitored (any state other than IDLE).
- pulse_count  out  8  pulses counted in the current/last frame; saturates at 255.
- last_width  out  16  width of the most recent completed pulse; saturates at 0xFFFF.
- last_period  out  16  period of the most recent measured pulse pair; saturates.
- width_err  out  1  sticky: at least one pulse width was outside ON_CYCLES±TOL.
- period_err  out  1  sticky: at least one period was outside PERIOD_CYCLES±TOL.
- count_err  out  1  sticky: pulse_count != N_PULSES at eof.
- timeout_err  out  1  sticky: the frame was aborted by timeout.
- frame_done  out  1  one-cycle strobe at frame end (eof or timeout).
- frame_ok  out  1  valid from the frame_done cycle onward; held until the next sof; 1 only if all four errors are clear.

Behaviour:
- Reset: every output is 0, FSM is in IDLE, all internal counters and input delay flops are 0.
- Edge detection: each input passes through one delay flop. A rising edge is x & ~x_d; a falling edge is ~x & x_d. All outputs are registered and update on the clock after the edge cycle.
- IDLE state:
  - Waits for a rising edge on sof.
  - pri and eof activity is ignored.
  - On sof rise: clear pulse_count, last_width, last_period, all error flags and frame_ok, then go to SOF.
- SOF state:
  - Waits for sof to fall, then goes to RUN.
  - The timeout counter does not run in SOF.
- RUN state:
  - Timeout counter runs; it is cleared to 0 on every pri edge and on entry to RUN.
  - pri rise:
    - width_cnt <= 1; increment pulse_count (saturating).
    - If this is not the first pulse, compare period_cnt against PERIOD_CYCLES±TOL (set period_err on mismatch) and update last_period.
    - Then period_cnt <= 1.
  - width_cnt and period_cnt increment every cycle and saturate at 0xFFFF. The value held on an edge cycle therefore equals the exact cycle count: a 2048-cycle pulse reads 2048.
  - pri fall: compare width_cnt against ON_CYCLES±TOL (set width_err on mismatch); last_width <= width_cnt.
  - eof rise:
    - If pri is high (pulse truncated), set width_err.
    - Set count_err if pulse_count != N_PULSES.
    - Go to DONE.
  - Timeout counter reaches TIMEOUT: set timeout_err and go to DONE.
  - sof rise mid-frame: abort without a frame_done strobe, clear statistics and errors, go to SOF.
- DONE state (one cycle):
  - frame_done = 1.
  - frame_ok <= ~(width_err | period_err | count_err | timeout_err), using the flags as updated for this frame.
  - Next state is IDLE.
- Simultaneous events in RUN:
  - eof rise together with pri rise: the pulse is counted first, then the eof check runs (count includes it; truncated, so width_err is set).
  - Timeout together with eof rise: eof wins and timeout_err stays clear.
- Tolerance compare: |measured − expected| <= TOL, computed in 17-bit signed arithmetic. A saturated count always fails.
- Reset asserted mid-frame returns the block to the reset state on the next clock. No frame_done is produced.

Test Plan:
- Nominal frame (sof 400 cycles, 5000 idle, 50 pulses of 2048 high / 6145 period, eof 1200 cycles after 2000 gap) -> frame_done once, frame_ok=1, pulse_count=50, last_width=2048, last_period=6145, all errors 0.
- Pulse #10 width 2051 with TOL=2 -> width_err=1, frame_ok=0, period_err=0; width 2050 in a separate run -> no error (boundary).
- Frame with 49 pulses -> count_err=1, frame_ok=0, pulse_count=49.
- eof withheld after the last pulse -> timeout_err=1 and frame_done exactly TIMEOUT cycles after the last pri fall; busy=0 afterwards.
- Second sof rise at pulse 20 -> no frame_done, counters restart, and the following complete frame reports pulse_count=50, frame_ok=1.
- reset pulsed for 1 cycle at pulse 30 -> all outputs 0 next cycle; pri activity before the next sof is ignored (pulse_count stays 0).
